uart_receiver: RTL and testbench

- Asynchronous serial receiver, 8N1 format: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high); line idles high.
- Oversamples the serial line with the system clock and samples each bit at its centre.
- Presents each received byte on a parallel output with a one-cycle strobe.
- Sits between the external RX pin and a byte-consumer (FIFO/controller) in the UART controller.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_receiver.sv | 129 ++++++++++++
 tb/tb_uart_receiver.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// FSM state encoding, frame width and default bit timing.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CLK_HZ    = 100_000_000;
  localparam int BAUD      = 9600;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports: clk, rst (sync, active-high), d (async in), q (synced out).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, centre-sampled, one-cycle byte strobe.
// Ports: clk_i, nreset_i (sync active-high), rx_i, valid_i -> ready_o, data_o.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       rx_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] data_o
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk_i),
    .rst(nreset_i),
    .d  (rx_i),
    .q  (rx_s)
  );

  always_ff @(posedge clk_i) begin
    if (nreset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // enable gates only the start of a frame
        if (!rx_s && valid_i) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        // leaving at mid stop bit leaves room for a back-to-back start
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready_o = ready_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed plan plus random frames.
// Expected bytes/pulse counts come from frame-level acceptance rules.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       nreset = 1'b1;
  logic       rx = 1'b1;
  logic       valid = 1'b0;
  logic       ready;
  logic [7:0] data;

  uart_receiver #(
    .CLK_PER_BIT(CPB)
  ) dut (
    .clk_i   (clk),
    .nreset_i(nreset),
    .rx_i    (rx),
    .valid_i (valid),
    .ready_o (ready),
    .data_o  (data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         pulses = 0;
  int         multi = 0;
  int         bad_change = 0;
  int         pulse_cyc = 0;
  logic [7:0] pulse_byte = 8'h00;
  logic [7:0] prev_data = 8'h00;
  logic       prev_ready = 1'b0;

  int         exp_pulses = 0;
  logic [7:0] exp_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ready === 1'b1) begin
      pulses++;
      pulse_byte = data;
      pulse_cyc  = cyc;
      if (prev_ready) multi++;
    end else if (data !== prev_data && nreset !== 1'b1) begin
      bad_change++;
    end
    prev_ready = (ready === 1'b1);
    prev_data  = data;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // A frame yields a byte only if enabled at its start and stop bit is high.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input bit en);
    valid = en;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    if (stop_ok) begin
      hold(1'b1, CPB);
    end else begin
      hold(1'b0, 3 * CPB);
      hold(1'b1, CPB);
    end
    valid = 1'b1;
    if (en && stop_ok) begin
      exp_pulses++;
      exp_data = b;
    end
  endtask

  task automatic chk_frame(input string tag);
    chk({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    chk({tag, "_data"}, 32'(data), 32'(exp_data));
  endtask

  initial begin
    int c0;
    int lat;
    logic [7:0] b;
    bit en;
    bit ok;

    repeat (5) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_data", 32'(data), 32'd0);
    chk("reset_state", 32'(dut.state_q), 32'(IDLE));

    valid = 1'b1;
    hold(1'b1, 500);
    chk_frame("idle");

    c0 = cyc;
    send_frame(8'h81, 1'b1, 1'b1);
    chk_frame("f81");
    chk("f81_byte", 32'(pulse_byte), 32'h81);
    lat = pulse_cyc - c0;
    ok = (lat >= 2 + CPB / 2 + 9 * CPB - 3) &&
         (lat <= 2 + CPB / 2 + 9 * CPB + 3);
    chk("f81_latency_ok", 32'(ok), 32'd1);

    send_frame(8'h80, 1'b1, 1'b1);
    chk("b2b_first", 32'(pulse_byte), 32'h80);
    send_frame(8'h00, 1'b1, 1'b1);
    chk_frame("b2b");

    send_frame(8'h55, 1'b1, 1'b0);
    chk_frame("dis55");
    hold(1'b1, CPB);
    send_frame(8'hF1, 1'b1, 1'b1);
    chk_frame("fF1");

    hold(1'b1, CPB);
    hold(1'b0, CPB / 2 - 4);
    hold(1'b1, 2 * CPB);
    chk_frame("glitch");
    send_frame(8'h3C, 1'b1, 1'b1);
    chk_frame("f3C");

    send_frame(8'hA5, 1'b0, 1'b1);
    chk_frame("badA5");
    send_frame(8'h5A, 1'b1, 1'b1);
    chk_frame("f5A");

    for (int i = 0; i < 16; i++) begin
      b  = 8'($urandom);
      en = ($urandom_range(0, 3) != 0);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok, en);
      chk_frame($sformatf("rnd%0d", i));
      hold(1'b1, $urandom_range(0, CPB));
    end

    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB / 2);
    nreset = 1'b1;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    nreset = 1'b0;
    exp_data = 8'h00;
    hold(1'b1, 12 * CPB);
    chk_frame("midrst");
    chk("midrst_state", 32'(dut.state_q), 32'(IDLE));

    send_frame(8'hC3, 1'b1, 1'b1);
    chk_frame("fC3");

    chk("single_cycle_pulses", 32'(multi), 32'd0);
    chk("data_stable_no_strobe", 32'(bad_change), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
